// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches from a combinational ROM into a small FIFO.
// Optional FETCH_PERF_EN adds saturating fetch/flush counters.
module fetch_sequencer #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] mem_addr,
    input  logic [31:0] mem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        br_valid,
    input  logic [63:0] br_target,
    output logic        done,
    output logic        fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StEnd, StFault} state_e;

    localparam int unsigned Slots = 4;
    // Last word-aligned PC that still fits entirely inside the ROM.
    localparam logic [63:0] PcLast = 64'(MEM_BYTES) - 64'd4;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic        done_q, done_d, fault_q, fault_d;
    logic [63:0] fifo_pc_q [Slots];
    logic [63:0] fifo_pc_d [Slots];
    logic [31:0] fifo_instr_q [Slots];
    logic [31:0] fifo_instr_d [Slots];

    logic in_bounds, redirect, pop, push;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        in_bounds = (pc_q <= PcLast);
        redirect  = br_valid && (state_q == StFetch || state_q == StEnd);
        out_valid = (count_q != 3'd0) && !br_valid;
        pop       = out_valid && out_ready;
        push      = (state_q == StFetch) && !br_valid && in_bounds &&
                    ((count_q < 3'(DEPTH)) || pop);

        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;

        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (!br_valid && !in_bounds) state_d = StEnd;
            StEnd:   state_d = StEnd;
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase

        if (redirect) begin
            count_d  = 3'd0;
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            if (br_target[1:0] == 2'b00) begin
                pc_d    = br_target;
                state_d = StFetch;
            end else begin
                state_d = StFault;
            end
        end else begin
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push) begin
                fifo_pc_d[wr_ptr_q]    = pc_q;
                fifo_instr_d[wr_ptr_q] = mem_instr;
                wr_ptr_d               = ptr_inc(wr_ptr_q);
                pc_d                   = pc_q + 64'd4;
            end
            count_d = count_q + {2'b00, push} - {2'b00, pop};
        end

        done_d  = (state_d == StEnd) && (count_d == 3'd0);
        fault_d = (state_d == StFault);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            count_q  <= 3'd0;
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            for (int i = 0; i < Slots; i++) begin
                fifo_pc_q[i]    <= 64'd0;
                fifo_instr_q[i] <= 32'd0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
        end
    end

    assign mem_addr  = pc_q;
    assign out_instr = fifo_instr_q[rd_ptr_q];
    assign out_pc    = fifo_pc_q[rd_ptr_q];
    assign done      = done_q;
    assign fault     = fault_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (push && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random redirect/backpressure
// traffic compared against a queue-based reference model.
module tb_fetch_sequencer;

    localparam int unsigned MemBytes = 64;
    localparam int unsigned Depth    = 2;
    localparam logic [63:0] ResetPc  = 64'd0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] mem_addr;
    logic [31:0] mem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        br_valid;
    logic [63:0] br_target;
    logic        done;
    logic        fault;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(
        .MEM_BYTES(MemBytes),
        .RESET_PC (ResetPc),
        .DEPTH    (Depth)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mem_addr (mem_addr),
        .mem_instr(mem_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc   (out_pc),
        .br_valid (br_valid),
        .br_target(br_target),
        .done     (done),
        .fault    (fault)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count(fetch_count),
        .flush_count(flush_count)
`endif
    );

    logic [31:0] rom [16];

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        if (a < 64'(MemBytes)) return rom[a[5:2]];
        return 32'hDEAD_BEEF;
    endfunction

    always_comb mem_instr = rom_word(mem_addr);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_pc;
    bit          m_started, m_ended, m_fault;
    int unsigned m_fetches, m_flushes;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc      = ResetPc;
        m_started = 0;
        m_ended   = 0;
        m_fault   = 0;
        m_fetches = 0;
        m_flushes = 0;
    endtask

    // Called at a negedge; asserts reset, checks the async clear, releases on a later negedge.
    task automatic do_reset();
        br_valid  = 1'b0;
        br_target = 64'd0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_mem_addr", mem_addr, ResetPc);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One cycle: drive at negedge, check, advance the model at posedge, return at next negedge.
    task automatic step(input logic bv, input logic [63:0] bt, input logic rdy);
        bit popped;
        bit exp_valid;
        br_valid  = bv;
        br_target = bt;
        out_ready = rdy;
        #1;
        exp_valid = (q.size() != 0) && !bv;
        chk("mem_addr", mem_addr, m_pc);
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", 64'(out_instr), 64'(q[0].instr));
        end
        chk("done", 64'(done), 64'(m_ended && q.size() == 0 && !m_fault));
        chk("fault", 64'(fault), 64'(m_fault));
`ifdef FETCH_PERF_EN
        chk("fetch_count", 64'(fetch_count), 64'(m_fetches));
        chk("flush_count", 64'(flush_count), 64'(m_flushes));
`endif
        @(posedge clk);
        if (m_fault) begin
        end else if (!m_started) begin
            m_started = 1;
        end else if (bv) begin
            q.delete();
            m_flushes++;
            if (bt % 4 == 0) begin
                m_pc    = bt;
                m_ended = 0;
            end else begin
                m_fault = 1;
            end
        end else begin
            popped = (q.size() != 0) && rdy;
            if (popped) void'(q.pop_front());
            if (!m_ended) begin
                if (({1'b0, m_pc} + 65'd3) < 65'(MemBytes)) begin
                    if (q.size() < Depth) begin
                        q.push_back('{pc: m_pc, instr: rom_word(m_pc)});
                        m_fetches++;
                        m_pc = m_pc + 64'd4;
                    end
                end else begin
                    m_ended = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] tgt;
        int          r;
        for (int i = 0; i < 16; i++) rom[i] = $urandom;
        reset_n   = 1'b0;
        br_valid  = 1'b0;
        br_target = 64'd0;
        out_ready = 1'b0;
        @(negedge clk);

        // Straight-line run to the end of the ROM.
        do_reset();
        repeat (22) step(1'b0, 64'd0, 1'b1);
        chk("end_done", 64'(done), 64'd1);
        step(1'b1, 64'd0, 1'b1);
        repeat (4) step(1'b0, 64'd0, 1'b1);

        // Backpressure, then reset with two entries queued and PC = 0x10.
        do_reset();
        repeat (7) step(1'b0, 64'd0, 1'b0);
        chk("bp_mem_addr", mem_addr, 64'd8);
        repeat (2) step(1'b0, 64'd0, 1'b1);
        chk("pre_rst_pc", mem_addr, 64'h10);
        do_reset();
        repeat (8) step(1'b0, 64'd0, 1'b1);

        // Redirect to 0x20 while FIFO holds words 0 and 4.
        do_reset();
        repeat (3) step(1'b0, 64'd0, 1'b0);
        step(1'b1, 64'h20, 1'b1);
        step(1'b0, 64'd0, 1'b1);
        chk("redir_head", out_pc, 64'h20);
        repeat (3) step(1'b0, 64'd0, 1'b1);

        // Misaligned redirect; later redirects are ignored.
        step(1'b1, 64'h22, 1'b1);
        chk("fault_set", 64'(fault), 64'd1);
        repeat (3) step(1'b0, 64'd0, 1'b1);
        step(1'b1, 64'd0, 1'b1);
        repeat (3) step(1'b0, 64'd0, 1'b1);
        chk("fault_sticky", 64'(fault), 64'd1);

        // Redirect near 2^64 is out of bounds; a later redirect resumes.
        do_reset();
        repeat (4) step(1'b0, 64'd0, 1'b1);
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        repeat (3) step(1'b0, 64'd0, 1'b1);
        step(1'b1, 64'h30, 1'b1);
        repeat (6) step(1'b0, 64'd0, 1'b1);

        // Random traffic.
        for (int seg = 0; seg < 30; seg++) begin
            do_reset();
            for (int c = 0; c < 100; c++) begin
                r = int'($urandom_range(0, 99));
                if (r < 6) begin
                    tgt = 64'($urandom_range(0, 20)) * 64'd4;
                    step(1'b1, tgt, 1'($urandom));
                end else if (r == 6) begin
                    tgt = 64'($urandom_range(0, 80)) | 64'd1;
                    step(1'b1, tgt, 1'($urandom));
                end else if (r == 7) begin
                    step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'($urandom));
                end else begin
                    step(1'b0, 64'($urandom), ($urandom_range(0, 3) != 0));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the single-cycle/pipelined ARM core. It owns the program counter, drives the byte address into the combinational instruction ROM, and buffers fetched words in a small FIFO toward decode. Decode consumes words through a valid/ready handshake, and the execute stage redirects fetch on taken branches. The block stops cleanly when the PC leaves the ROM and flags misaligned redirect targets.

## Interface
Parameters:
- MEM_BYTES, 1024: ROM size in bytes; must be a power of two and ≥ 8.
- RESET_PC, 64'd0: PC loaded on reset; word-aligned.
- DEPTH, 2: FIFO entries; range 1–4.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_addr  out  64  byte address to the ROM; equals the PC register.
- mem_instr  in  32  ROM read data; combinational from mem_addr.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction.
- out_pc  out  64  byte address the head instruction was fetched from.
- br_valid  in  1  redirect request from execute.
- br_target  in  64  redirect byte address.
- done  out  1  PC has left the ROM and the FIFO is empty.
- fault  out  1  a misaligned redirect was received; sticky until reset.

## Operation
- States: IDLE, FETCH, END, FAULT.
- IDLE: entered on reset; unconditionally moves to FETCH on the next edge.
- FETCH: a fetch occurs when the FIFO has space (count < DEPTH, or a pop happens in the same cycle) and the PC is in bounds.
  - On a fetch, push {PC, mem_instr} and set PC = PC + 4.
- In bounds means PC + 3 < MEM_BYTES. If the PC is out of bounds in FETCH, make no push and go to END.
- Redirect (br_valid = 1 in FETCH or END):
  - Flush the FIFO (count = 0).
  - No push and no pop take effect that cycle.
  - If br_target[1:0] == 0: PC = br_target, next state FETCH.
  - Otherwise: PC is unchanged, next state FAULT.
- Redirect priority: redirect > pop > push.
- END: no fetches. The FIFO drains normally. done = (count == 0).
- FAULT: terminal until reset. FIFO is flushed, out_valid = 0, fault = 1, br_valid is ignored.
- out_valid = (count != 0) && !br_valid. A handshake in a redirect cycle is discarded, and decode must not consume it.
- Arithmetic: PC + 4 and the bound check are computed in 64 bits with no wrap. A PC near 2^64 is simply out of bounds.
- A redirect to an in-bounds target from END resumes fetching.

## Timing
- Reset values: PC = RESET_PC, count = 0, state = IDLE, out_valid = 0, done = 0, fault = 0, and the FIFO pointers are 0.
- Assertion of reset_n = 0 mid-operation clears everything immediately and asynchronously. Deassertion is sampled on the clk edge.
- Fetch latency: the word at address A is pushed on the edge where PC = A and is visible on out_instr/out_pc in the following cycle.
- Throughput: one instruction per cycle when out_ready is held high.
- First out_valid: the third cycle after reset release (IDLE, then the fetch cycle, then valid).
- Redirect latency: target word appears at the FIFO head 2 cycles after the br_valid cycle.
- Full FIFO with out_ready = 1: push and pop occur in the same cycle and count is unchanged.
- Full FIFO with out_ready = 0: PC holds and mem_addr is stable.
- mem_addr, done and fault are glitch-free register outputs. out_valid is the only output with a combinational input (br_valid).

## Configuration
- FETCH_PERF_EN defined:
  - Adds output fetch_count [31:0] and output flush_count [15:0].
  - fetch_count increments on every push; flush_count increments on every accepted redirect.
  - Both counters saturate at all-ones and reset to 0.
- FETCH_PERF_EN undefined:
  - Neither port nor counter exists.
  - All other behaviour is identical.

## Test plan
- Straight-line run: MEM_BYTES = 16, out_ready = 1, ROM = {I0..I3}.
  - Expect out_pc 0, 4, 8, 12 on consecutive cycles, with out_instr matching.
  - Then END; done = 1 one cycle after the last pop, and no further out_valid.
- Backpressure: DEPTH = 2, out_ready = 0 for 5 cycles.
  - count reaches 2 and mem_addr holds at 8.
  - On raising out_ready, words at 0 and 4 pop in order, with no loss or duplication.
- Redirect: br_valid with br_target = 0x20 while the FIFO holds 0 and 4.
  - out_valid = 0 that cycle and the FIFO is flushed.
  - Two cycles later out_pc = 0x20.
- Misaligned redirect: br_target = 0x22.
  - fault = 1 on the next cycle and stays 1.
  - out_valid stays 0, and a later br_valid is ignored.
- Reset mid-run: drop reset_n while count = 2 and PC = 0x10.
  - out_valid, done, fault and count are 0 immediately, and mem_addr = RESET_PC.
  - Restart reproduces the straight-line sequence.
- FETCH_PERF_EN: run the straight-line sequence, then one redirect to 0.
  - Expect fetch_count = 4 before the redirect and flush_count = 1 after it.
